// File: rtl/camera_byte_pairer.sv
// camera_byte_pairer
//   Front end of the camera path. Oversamples a raw OV7670-style parallel bus
//   (pclk, href, vsync, data) in the system clock domain. It pairs consecutive
//   bytes into 16-bit RGB565 pixels and emits one valid strobe per pixel. It
//   also emits a frame-done pulse at the start of vertical blank.
//
//   Optional build macro: LINE_CHECK_EN
//     When defined, this adds a per-line pixel counter and a sticky
//     line_error_out flag. The flag is set by lines with the wrong length or
//     by lines that end on an odd byte.
//
// Ports
//   system_clk_in    system clock (65 MHz); the only clock
//   rst_in           asynchronous, active-high reset
//   cam_pclk_in      camera pixel clock pin, sampled as data
//   cam_href_in      camera line-active pin
//   cam_vsync_in     camera frame-sync pin, high = vertical blank
//   cam_data_in      camera data byte
//   pixel_out        assembled pixel {first byte, second byte}; held between pulses
//   valid_pixel_out  one-cycle strobe, pixel_out is new
//   frame_done_out   one-cycle pulse on the rising edge of vsync
//   line_error_out   sticky line-length error (LINE_CHECK_EN only)

module camera_byte_pairer #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned H_PIXELS    = 320
) (
   input  logic        system_clk_in,
   input  logic        rst_in,
   input  logic        cam_pclk_in,
   input  logic        cam_href_in,
   input  logic        cam_vsync_in,
   input  logic [7:0]  cam_data_in,
   output logic [15:0] pixel_out,
   output logic        valid_pixel_out,
   output logic        frame_done_out
`ifdef LINE_CHECK_EN
   ,
   output logic        line_error_out
`endif
);

   typedef enum logic [1:0] {
      StWaitFrame,
      StLineIdle,
      StByteLo
   } state_e;

   // ------------------------------------------------------------------
   // Input synchronizers. All pins use the same depth, so data, href and
   // pclk stay aligned with each other after synchronization.
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0]      pclk_sync_q;
   logic [SYNC_STAGES-1:0]      href_sync_q;
   logic [SYNC_STAGES-1:0]      vsync_sync_q;
   logic [SYNC_STAGES-1:0][7:0] data_sync_q;
   logic                        pclk_prev_q;
   logic                        vsync_prev_q;

   always_ff @(posedge system_clk_in or posedge rst_in) begin
      if (rst_in) begin
         pclk_sync_q  <= '0;
         href_sync_q  <= '0;
         vsync_sync_q <= '0;
         data_sync_q  <= '0;
         pclk_prev_q  <= 1'b0;
         vsync_prev_q <= 1'b0;
      end else begin
         pclk_sync_q  <= {pclk_sync_q[SYNC_STAGES-2:0], cam_pclk_in};
         href_sync_q  <= {href_sync_q[SYNC_STAGES-2:0], cam_href_in};
         vsync_sync_q <= {vsync_sync_q[SYNC_STAGES-2:0], cam_vsync_in};
         data_sync_q  <= {data_sync_q[SYNC_STAGES-2:0], cam_data_in};
         pclk_prev_q  <= pclk_sync_q[SYNC_STAGES-1];
         vsync_prev_q <= vsync_sync_q[SYNC_STAGES-1];
      end
   end

   logic       pclk_s;
   logic       href_s;
   logic       vsync_s;
   logic [7:0] data_s;
   logic       pclk_rise;
   logic       vsync_rise;
   logic       vsync_fall;

   assign pclk_s     = pclk_sync_q[SYNC_STAGES-1];
   assign href_s     = href_sync_q[SYNC_STAGES-1];
   assign vsync_s    = vsync_sync_q[SYNC_STAGES-1];
   assign data_s     = data_sync_q[SYNC_STAGES-1];
   assign pclk_rise  = pclk_s & ~pclk_prev_q;
   assign vsync_rise = vsync_s & ~vsync_prev_q;
   assign vsync_fall = ~vsync_s & vsync_prev_q;

   // ------------------------------------------------------------------
   // Pairing FSM
   // ------------------------------------------------------------------
   state_e state_q, state_d;

   logic capture_hi;
   logic emit;

   // href during vertical blank is ignored. A vsync rise in the same cycle
   // as a second-byte edge suppresses the pixel.
   assign capture_hi = (state_q == StLineIdle) & pclk_rise & href_s & ~vsync_s;
   assign emit       = (state_q == StByteLo) & pclk_rise & href_s & ~vsync_rise;

   // State register
   always_ff @(posedge system_clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= StWaitFrame;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (vsync_rise) begin
         state_d = StWaitFrame;
      end else begin
         unique case (state_q)
            StWaitFrame: begin
               if (vsync_fall) begin
                  state_d = StLineIdle;
               end
            end
            StLineIdle: begin
               if (capture_hi) begin
                  state_d = StByteLo;
               end
            end
            StByteLo: begin
               // Line ended on an odd byte: drop the pending high byte.
               if (!href_s || emit) begin
                  state_d = StLineIdle;
               end
            end
            default: state_d = StWaitFrame;
         endcase
      end
   end

   // Output / datapath next-state logic
   logic [7:0]  hi_byte_q, hi_byte_d;
   logic [15:0] pixel_q, pixel_d;
   logic        valid_q, valid_d;
   logic        frame_done_q, frame_done_d;

   always_comb begin
      hi_byte_d    = hi_byte_q;
      pixel_d      = pixel_q;
      valid_d      = 1'b0;
      frame_done_d = vsync_rise;
      if (vsync_rise || ((state_q == StByteLo) && !href_s)) begin
         hi_byte_d = 8'h00;
      end else if (capture_hi) begin
         hi_byte_d = data_s;
      end
      if (emit) begin
         pixel_d = {hi_byte_q, data_s};
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge system_clk_in or posedge rst_in) begin
      if (rst_in) begin
         hi_byte_q    <= 8'h00;
         pixel_q      <= 16'h0000;
         valid_q      <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         hi_byte_q    <= hi_byte_d;
         pixel_q      <= pixel_d;
         valid_q      <= valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign pixel_out       = pixel_q;
   assign valid_pixel_out = valid_q;
   assign frame_done_out  = frame_done_q;

`ifdef LINE_CHECK_EN
   // ------------------------------------------------------------------
   // Line-length checker
   // ------------------------------------------------------------------
   localparam logic [10:0] HPixW = 11'(H_PIXELS);

   logic        href_prev_q;
   logic        href_fall;
   logic        odd_end;
   logic [10:0] line_cnt_q, line_cnt_d;
   logic        line_error_q, line_error_d;

   assign href_fall = ~href_s & href_prev_q;
   // A falling href while a high byte is still pending means an odd byte count.
   assign odd_end   = (state_q == StByteLo) & href_fall;

   always_comb begin
      line_cnt_d   = line_cnt_q;
      line_error_d = line_error_q;
      if (href_fall || vsync_rise) begin
         line_cnt_d = 11'd0;
      end else if (emit && (line_cnt_q != 11'h7ff)) begin
         // Saturate so that an overlong line cannot wrap back to zero.
         line_cnt_d = line_cnt_q + 11'd1;
      end
      if (href_fall &&
          (((line_cnt_q != HPixW) && (line_cnt_q != 11'd0)) || odd_end)) begin
         line_error_d = 1'b1;
      end
   end

   always_ff @(posedge system_clk_in or posedge rst_in) begin
      if (rst_in) begin
         href_prev_q  <= 1'b0;
         line_cnt_q   <= 11'd0;
         line_error_q <= 1'b0;
      end else begin
         href_prev_q  <= href_s;
         line_cnt_q   <= line_cnt_d;
         line_error_q <= line_error_d;
      end
   end

   assign line_error_out = line_error_q;
`endif

endmodule

// File: tb/tb_camera_byte_pairer.sv
// Directed bench for camera_byte_pairer with hand-computed expected values.
module tb_camera_byte_pairer;

   localparam int unsigned SyncStages = 2;

   logic        system_clk_in = 1'b0;
   logic        rst_in;
   logic        cam_pclk_in;
   logic        cam_href_in;
   logic        cam_vsync_in;
   logic [7:0]  cam_data_in;
   logic [15:0] pixel_out;
   logic        valid_pixel_out;
   logic        frame_done_out;
`ifdef LINE_CHECK_EN
   logic        line_error_out;
`endif

   always #5 system_clk_in = ~system_clk_in;

   camera_byte_pairer #(
      .SYNC_STAGES (SyncStages),
      .H_PIXELS    (320)
   ) dut (
      .system_clk_in   (system_clk_in),
      .rst_in          (rst_in),
      .cam_pclk_in     (cam_pclk_in),
      .cam_href_in     (cam_href_in),
      .cam_vsync_in    (cam_vsync_in),
      .cam_data_in     (cam_data_in),
      .pixel_out       (pixel_out),
      .valid_pixel_out (valid_pixel_out),
      .frame_done_out  (frame_done_out)
`ifdef LINE_CHECK_EN
      ,
      .line_error_out  (line_error_out)
`endif
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Monitor: record every valid pixel and its cycle, count frame-done pulses,
   // and flag any strobe that stays high for two samples in a row.
   int unsigned cyc_cnt = 0;
   logic [15:0] pix_q[$];
   int unsigned vcyc_q[$];
   int          fd_cnt    = 0;
   int          width_err = 0;
   logic        valid_prev = 1'b0;
   logic        fd_prev    = 1'b0;

   always @(posedge system_clk_in) cyc_cnt <= cyc_cnt + 1;

   always @(negedge system_clk_in) begin
      if (valid_pixel_out === 1'b1) begin
         pix_q.push_back(pixel_out);
         vcyc_q.push_back(cyc_cnt);
      end
      if (frame_done_out === 1'b1) fd_cnt++;
      if ((valid_prev && valid_pixel_out) || (fd_prev && frame_done_out)) width_err++;
      valid_prev = valid_pixel_out;
      fd_prev    = frame_done_out;
   end

   int unsigned last_rise;

   task automatic cyc(input int n);
      repeat (n) @(negedge system_clk_in);
   endtask

   task automatic send_byte(input logic [7:0] b, input int lo, input int hi);
      cam_pclk_in = 1'b0;
      cam_data_in = b;
      cyc(lo);
      cam_pclk_in = 1'b1;
      last_rise   = cyc_cnt;
      cyc(hi);
   endtask

   task automatic end_line();
      cam_pclk_in = 1'b0;
      cam_href_in = 1'b0;
      cyc(6);
   endtask

   task automatic line_ab(input int n);
      cam_href_in = 1'b1;
      for (int i = 0; i < n; i++) begin
         send_byte(8'hAB, 2, 2);
         send_byte(8'hCD, 2, 2);
      end
      end_line();
   endtask

   task automatic frame_sync();
      cam_vsync_in = 1'b1;
      cyc(6);
      cam_vsync_in = 1'b0;
      cyc(6);
   endtask

   task automatic clear_mon();
      pix_q.delete();
      vcyc_q.delete();
   endtask

   int fd_base;
   int bad;
   int unsigned t2;

   initial begin
      rst_in       = 1'b1;
      cam_pclk_in  = 1'b0;
      cam_href_in  = 1'b0;
      cam_vsync_in = 1'b0;
      cam_data_in  = 8'h00;
      cyc(3);
      check_eq("rst_pixel", pixel_out, 0);
      check_eq("rst_valid", valid_pixel_out, 0);
      check_eq("rst_frame_done", frame_done_out, 0);
`ifdef LINE_CHECK_EN
      check_eq("rst_line_error", line_error_out, 0);
`endif
      rst_in = 1'b0;
      cyc(4);

      // No vsync fall since reset: everything is ignored.
      line_ab(320);
      line_ab(320);
      check_eq("wait_frame_pulses", pix_q.size(), 0);
      fd_base = fd_cnt;
      frame_sync();
      check_eq("sync_frame_done", fd_cnt - fd_base, 1);
      clear_mon();
      line_ab(320);
      check_eq("full_line_pulses", pix_q.size(), 320);
      bad = 0;
      foreach (pix_q[i]) if (pix_q[i] !== 16'hABCD) bad++;
      check_eq("full_line_bad_pixels", bad, 0);
`ifdef LINE_CHECK_EN
      check_eq("full_line_no_error", line_error_out, 0);
`endif

      // Two pixels with latency measurement.
      clear_mon();
      cam_href_in = 1'b1;
      send_byte(8'h12, 2, 2);
      send_byte(8'h34, 2, 2);
      t2 = last_rise;
      send_byte(8'h56, 2, 2);
      send_byte(8'h78, 2, 2);
      end_line();
      check_eq("two_px_count", pix_q.size(), 2);
      if (pix_q.size() == 2) begin
         check_eq("two_px_first", pix_q[0], 16'h1234);
         check_eq("two_px_second", pix_q[1], 16'h5678);
         check_eq("two_px_latency", vcyc_q[0] - t2, SyncStages + 1);
      end
      check_eq("pulse_width", width_err, 0);

      // vsync rises mid-line; nothing more until the next fall.
      clear_mon();
      fd_base = fd_cnt;
      cam_href_in = 1'b1;
      send_byte(8'h99, 2, 2);
      cam_vsync_in = 1'b1;
      send_byte(8'h98, 2, 2);
      send_byte(8'h97, 2, 2);
      end_line();
      line_ab(4);
      check_eq("vsync_mid_frame_done", fd_cnt - fd_base, 1);
      check_eq("vsync_mid_no_pulses", pix_q.size(), 0);
      cam_vsync_in = 1'b0;
      cyc(6);

      // Odd-length line, then a fresh line.
      clear_mon();
      cam_href_in = 1'b1;
      send_byte(8'h11, 2, 2);
      send_byte(8'h22, 2, 2);
      send_byte(8'h33, 2, 2);
      end_line();
      cam_href_in = 1'b1;
      send_byte(8'h44, 2, 2);
      send_byte(8'h55, 2, 2);
      end_line();
      check_eq("odd_line_count", pix_q.size(), 2);
      if (pix_q.size() == 2) begin
         check_eq("odd_line_px", pix_q[0], 16'h1122);
         check_eq("fresh_line_px", pix_q[1], 16'h4455);
      end
`ifdef LINE_CHECK_EN
      check_eq("odd_line_error", line_error_out, 1);
      cyc(20);
      check_eq("line_error_sticky", line_error_out, 1);
`endif

      // Asynchronous reset with a half pixel pending.
      clear_mon();
      cam_href_in = 1'b1;
      send_byte(8'hAA, 2, 4);
      check_eq("pre_reset_pixel", pixel_out, 16'h4455);
      rst_in = 1'b1;
      #1;
      check_eq("async_rst_pixel", pixel_out, 0);
      check_eq("async_rst_valid", valid_pixel_out, 0);
      cyc(2);
      rst_in = 1'b0;
      send_byte(8'hBB, 2, 2);
      end_line();
      line_ab(2);
      check_eq("post_reset_no_pulses", pix_q.size(), 0);
      frame_sync();
      cam_href_in = 1'b1;
      send_byte(8'h01, 2, 2);
      send_byte(8'h02, 2, 2);
      end_line();
      check_eq("resume_count", pix_q.size(), 1);
      if (pix_q.size() == 1) check_eq("resume_px", pix_q[0], 16'h0102);

      // pclk at system/3, vsync rise on the second-byte edge.
      clear_mon();
      fd_base = fd_cnt;
      cam_href_in = 1'b1;
      send_byte(8'h5A, 1, 2);
      cam_pclk_in = 1'b0;
      cam_data_in = 8'hA5;
      cyc(1);
      cam_pclk_in  = 1'b1;
      cam_vsync_in = 1'b1;
      cyc(3);
      end_line();
      check_eq("coincide_frame_done", fd_cnt - fd_base, 1);
      check_eq("coincide_no_valid", pix_q.size(), 0);
      cam_vsync_in = 1'b0;
      cyc(6);
      check_eq("final_pulse_width", width_err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
